// File: rtl/regfile_pkg.sv
// Shared constants, link-stack operation encoding and reset-pattern helper
// for the regfile_lrstack register file.
package regfile_pkg;

    // Default geometry of the register file and link stack.
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_NREGS    = 4;
    localparam int unsigned DEF_LR_DEPTH = 4;

    // Decoded link-stack operation for one clock edge, already resolved by
    // priority and by the current full/empty state.
    typedef enum logic [2:0] {
        LR_OP_NONE      = 3'd0,
        LR_OP_REPLACE   = 3'd1,
        LR_OP_PUSH      = 3'd2,
        LR_OP_OVERFLOW  = 3'd3,
        LR_OP_POP       = 3'd4,
        LR_OP_UNDERFLOW = 3'd5
    } lr_op_e;

    // Reset value of register i: its own index truncated to 'width' bits.
    // Callers cast the result to their data width.
    function automatic logic [31:0] reset_val(input int unsigned i,
                                              input int unsigned width);
        logic [31:0] mask_v;
        logic [31:0] idx_v;
        idx_v = i;
        if (width >= 32) begin
            mask_v = 32'hFFFF_FFFF;
        end else begin
            mask_v = (32'd1 << width) - 32'd1;
        end
        return idx_v & mask_v;
    endfunction

endpackage

// File: rtl/regfile_lrstack_lr_stack.sv
// Link-register return stack: LIFO of DEPTH entries with occupancy count,
// full/empty decode and a sticky overflow/underflow error flag.
// One operation per edge; simultaneous push+pop on a non-empty stack
// replaces the top entry, on an empty stack it behaves as a plain push.
module lr_stack
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_LR_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);

    localparam int unsigned   IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             err_q;
    logic             err_d;

    lr_op_e           op_s;
    logic             full_s;
    logic             empty_s;
    logic [IW-1:0]    top_idx_s;
    logic [IW-1:0]    push_idx_s;

    // Occupancy decode and entry indices derived from the count.
    // top_idx_s is only meaningful when non-empty, push_idx_s only when not full.
    assign full_s     = (count_q == DEPTH_C);
    assign empty_s    = (count_q == {CW{1'b0}});
    assign top_idx_s  = IW'(count_q - ONE_C);
    assign push_idx_s = IW'(count_q);

    // Resolve push/pop requests into a single prioritised operation.
    always_comb begin
        op_s = LR_OP_NONE;
        if (push_i && pop_i && !empty_s) begin
            op_s = LR_OP_REPLACE;
        end else if (push_i) begin
            if (full_s) begin
                op_s = LR_OP_OVERFLOW;
            end else begin
                op_s = LR_OP_PUSH;
            end
        end else if (pop_i) begin
            if (empty_s) begin
                op_s = LR_OP_UNDERFLOW;
            end else begin
                op_s = LR_OP_POP;
            end
        end else begin
            op_s = LR_OP_NONE;
        end
    end

    // Next-state computation for entries, count and the sticky error flag.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        err_d   = err_q;
        case (op_s)
            LR_OP_REPLACE: begin
                entry_d[top_idx_s] = din_i;
            end
            LR_OP_PUSH: begin
                entry_d[push_idx_s] = din_i;
                count_d             = count_q + ONE_C;
            end
            LR_OP_OVERFLOW: begin
                err_d = 1'b1;
            end
            LR_OP_POP: begin
                count_d = count_q - ONE_C;
            end
            LR_OP_UNDERFLOW: begin
                err_d = 1'b1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers; reset clears count, error and (for determinism) entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
            err_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            entry_q <= entry_d;
        end
    end

    // Top-of-stack read: zero when empty so a stray RETURN sees a clean value.
    always_comb begin
        top_o = {WIDTH{1'b0}};
        if (empty_s) begin
            top_o = {WIDTH{1'b0}};
        end else begin
            top_o = entry_q[top_idx_s];
        end
    end

    assign count_o = count_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign err_o   = err_q;

endmodule

// File: rtl/regfile_lrstack.sv
// Parametrised register file (two combinational read ports, one synchronous
// write port) with an integrated link-register return stack.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a same-cycle
// write to the address being read is forwarded to that read port.
module regfile_lrstack
    import regfile_pkg::*;
#(
    parameter int unsigned  WIDTH    = DEF_WIDTH,
    parameter int unsigned  NREGS    = DEF_NREGS,
    parameter int unsigned  LR_DEPTH = DEF_LR_DEPTH,
    localparam int unsigned AW       = $clog2(NREGS),
    localparam int unsigned CW       = $clog2(LR_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wd,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    rd1,
    input  logic [AW-1:0]    rd2,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    input  logic             lr_push,
    input  logic             lr_pop,
    input  logic [WIDTH-1:0] lr_din,
    output logic [WIDTH-1:0] lr_top,
    output logic [CW-1:0]    lr_count,
    output logic             lr_full,
    output logic             lr_empty,
    output logic             lr_err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Register write: every address is writable, no hardwired zero.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wd] = din;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array; reset loads each register with its own index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= WIDTH'(reset_val(i, WIDTH));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read port 1 with write-data forwarding to hide the WB->ID hazard.
    always_comb begin
        dout1 = regs_q[rd1];
        if (we && (wd == rd1)) begin
            dout1 = din;
        end else begin
            dout1 = regs_q[rd1];
        end
    end

    // Read port 2 with write-data forwarding to hide the WB->ID hazard.
    always_comb begin
        dout2 = regs_q[rd2];
        if (we && (wd == rd2)) begin
            dout2 = din;
        end else begin
            dout2 = regs_q[rd2];
        end
    end
`else
    // Read port 1: stored value only; a same-cycle write shows next cycle.
    always_comb begin
        dout1 = regs_q[rd1];
    end

    // Read port 2: stored value only; a same-cycle write shows next cycle.
    always_comb begin
        dout2 = regs_q[rd2];
    end
`endif

    lr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (LR_DEPTH),
        .CW    (CW)
    ) u_lr_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (lr_push),
        .pop_i   (lr_pop),
        .din_i   (lr_din),
        .top_o   (lr_top),
        .count_o (lr_count),
        .full_o  (lr_full),
        .empty_o (lr_empty),
        .err_o   (lr_err)
    );

endmodule

// File: doc/regfile_lrstack.md
# regfile_lrstack

Parametrised register file with an integrated link-register return stack, replacing the fixed 4×8 main register file and the single-entry LR in the simple CPU. It provides two asynchronous read ports and one synchronous write port in the ID/WB stages. It also provides a LIFO link stack of configurable depth for nested CALL/RETURN. All state is clocked by the pipeline clock; no writes are clocked from enables.

## Interface
Parameters:
- WIDTH, 8, data width of registers and link entries
- NREGS, 4, number of general registers (≥2, power of two)
- LR_DEPTH, 4, link-stack entries (≥1)
- AW (derived), $clog2(NREGS), register address width
- CW (derived), $clog2(LR_DEPTH+1), link count width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  register write enable
- wd  in  AW  write address
- din  in  WIDTH  write data
- rd1  in  AW  read address, port 1
- rd2  in  AW  read address, port 2
- dout1  out  WIDTH  read data, port 1
- dout2  out  WIDTH  read data, port 2
- lr_push  in  1  push lr_din (CALL)
- lr_pop  in  1  pop top entry (RETURN)
- lr_din  in  WIDTH  return address to push
- lr_top  out  WIDTH  current top entry
- lr_count  out  CW  occupied entries
- lr_full  out  1  lr_count == LR_DEPTH
- lr_empty  out  1  lr_count == 0
- lr_err  out  1  sticky overflow/underflow flag

## Operation
- Reset (rst=1 at clk edge): regs[i] ← i[WIDTH-1:0]. Link count ← 0. lr_err ← 0. Link entry contents are don't-care.
- Register write: at a rising edge with we=1 and rst=0, regs[wd] ← din. All addresses are writable; there is no hardwired zero register.
- Reads: dout1 = regs[rd1] and dout2 = regs[rd2], combinational.
- Link stack, one operation per edge, priority as listed:
  - push=1, pop=1, non-empty: top entry replaced by lr_din; count unchanged.
  - push=1, pop=1, empty: treated as plain push.
  - push only, not full: entry[count] ← lr_din; count+1.
  - push only, full: no state change; lr_err ← 1.
  - pop only, non-empty: count−1.
  - pop only, empty: no state change; lr_err ← 1.
- lr_top = entry[count−1] when non-empty, else 0.
- lr_full and lr_empty are decoded from count.
- lr_err stays high until rst.
- rst takes priority over any simultaneous we, push or pop.

## Timing
- Write-to-read latency is 1 cycle: the new value appears on dout after the writing edge.
- Same-cycle write/read to the same address: see Configuration.
- lr_top is valid combinationally in the RETURN cycle. The pop takes effect at that cycle's edge, and the next-lower entry appears the following cycle.
- Push: the pushed value appears on lr_top the cycle after the edge.
- Values after reset: dout1 = rd1 and dout2 = rd2 (per the reset pattern); lr_top = 0, lr_count = 0, lr_empty = 1, lr_full = 0, lr_err = 0.
- There is no stall input. The caller gates we, push and pop.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When we=1 and wd==rd1, dout1 = din in the same cycle; dout2 behaves the same way for rd2.
  - This forwarding removes the WB→ID hazard bubble.
- REGFILE_BYPASS_EN undefined: reads always return the stored value. A same-cycle write is visible only from the next cycle.

## Structure
- Package regfile_pkg holds:
  - default WIDTH, NREGS and LR_DEPTH constants;
  - the function reset_val(i), which returns i truncated to WIDTH.
- Sub-module lr_stack holds the entries, count, full/empty/err logic and the push/pop priority. The top level instantiates it beside the register array and the read/bypass muxes.

## Test plan
- Reset, then set rd1=2, rd2=3 → dout1=0x02, dout2=0x03; lr_empty=1, lr_count=0, lr_err=0.
- Write we=1, wd=1, din=0xA5 while rd1=1:
  - with REGFILE_BYPASS_EN → dout1=0xA5 in the same cycle;
  - without it → 0x01, then 0xA5 the next cycle.
- Push 0x10, 0x20, 0x30, 0x40 (LR_DEPTH=4) → lr_full=1, lr_top=0x40. A fifth push of 0x50 → lr_err=1, lr_top still 0x40, lr_count=4.
- Pop four times → lr_top reads 0x30, 0x20, 0x10, then 0 with lr_empty=1. A fifth pop → lr_err=1, lr_count=0.
- With lr_top=0x20 and count=2, assert push=1 and pop=1 with lr_din=0x77 → lr_top=0x77, lr_count=2.
- Push 0x11 and write regs[0]=0xFF, then assert rst in the same cycle as a further push and write → regs[0]=0x00, lr_count=0, lr_err=0.
